// File: rtl/sc_et_accum_if.sv
// Handshake/bitstream bundle between the early-termination bitstream
// generator (master) and the stochastic-to-binary accumulator (slave).
interface sc_et_accum_if #(
  parameter int WIDTH      = 4,
  parameter int NUM_INPUTS = 2
);
  localparam int CNT_W = NUM_INPUTS * WIDTH + 1;

  logic                        bit_valid;
  logic                        bit_last;
  logic [NUM_INPUTS-1:0]       Xs;
  logic                        res_valid;
  logic                        res_ready;
  logic [NUM_INPUTS*WIDTH-1:0] res_vals;
  logic [CNT_W-1:0]            res_len;
  logic                        overrun;

  modport master (
    output bit_valid, bit_last, Xs, res_ready,
    input  res_valid, res_vals, res_len, overrun
  );

  modport slave (
    input  bit_valid, bit_last, Xs, res_ready,
    output res_valid, res_vals, res_len, overrun
  );
endinterface

// File: rtl/sc_et_accum.sv
// Stochastic-to-binary accumulator: counts ones per stream over one run,
// closes the run on the last bit, converts each count to a WIDTH-bit value
// scaled by the run length, and holds the result behind valid/ready.
module sc_et_accum #(
  parameter int WIDTH      = 4,
  parameter int NUM_INPUTS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  sc_et_accum_if.slave      bus
);

  localparam int CNT_W = NUM_INPUTS * WIDTH + 1;
  localparam int VAL_W = NUM_INPUTS * WIDTH;
  // Longest legal run: 2^(NUM_INPUTS*WIDTH) bits.
  localparam logic [CNT_W-1:0] MAX_LEN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_ones [NUM_INPUTS];
  logic               r_res_valid;
  logic [VAL_W-1:0]   r_res_vals;
  logic [CNT_W-1:0]   r_res_len;
  logic               r_overrun;

  logic               w_len_full;
  logic               w_accept;
  logic [CNT_W-1:0]   w_len_nxt;
  logic [CNT_W-1:0]   w_ones_nxt [NUM_INPUTS];
  int                 w_e;
  logic [VAL_W-1:0]   w_conv;

  // Position of the most significant set bit (floor log2); 0 for zero.
  function automatic int msb_idx(input logic [CNT_W-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < CNT_W; i++) begin
      if (v[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

  // Scale a ones count to WIDTH bits given the run exponent; saturates
  // when the stream was all ones (count == length gives 2^WIDTH).
  function automatic logic [WIDTH-1:0] conv_one(input logic [CNT_W-1:0] ones,
                                                input int               e);
    logic [CNT_W+WIDTH-1:0] wide;
    wide = {{WIDTH{1'b0}}, ones};
    if (e >= WIDTH) begin
      wide = wide >> (e - WIDTH);
    end else begin
      wide = wide << (WIDTH - e);
    end
    if (|wide[CNT_W+WIDTH-1:WIDTH]) begin
      return {WIDTH{1'b1}};
    end else begin
      return wide[WIDTH-1:0];
    end
  endfunction

  // Next-count and conversion of the counts including the current bit, so
  // the last bit of a run is folded into the registered result.
  always_comb begin
    w_len_full = (r_len == MAX_LEN);
    w_accept   = bus.bit_valid && !w_len_full;
    if (w_accept) begin
      w_len_nxt = r_len + ONE_CNT;
    end else begin
      w_len_nxt = r_len;
    end
    w_e    = msb_idx(w_len_nxt);
    w_conv = {VAL_W{1'b0}};
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (w_accept) begin
        w_ones_nxt[k] = r_ones[k] + {{(CNT_W-1){1'b0}}, bus.Xs[k]};
      end else begin
        w_ones_nxt[k] = r_ones[k];
      end
      w_conv[k*WIDTH +: WIDTH] = conv_one(w_ones_nxt[k], w_e);
    end
  end

  // ACC/HOLD FSM with counters and registered result outputs; clear wins
  // over everything and discards bits presented in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACC;
      r_len       <= {CNT_W{1'b0}};
      r_res_valid <= 1'b0;
      r_res_vals  <= {VAL_W{1'b0}};
      r_res_len   <= {CNT_W{1'b0}};
      r_overrun   <= 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
        r_ones[k] <= {CNT_W{1'b0}};
      end
    end else if (clear) begin
      r_state     <= S_ACC;
      r_len       <= {CNT_W{1'b0}};
      r_res_valid <= 1'b0;
      r_res_vals  <= {VAL_W{1'b0}};
      r_res_len   <= {CNT_W{1'b0}};
      r_overrun   <= 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
        r_ones[k] <= {CNT_W{1'b0}};
      end
    end else begin
      case (r_state)
        S_ACC: begin
          if (bus.bit_valid) begin
            r_len  <= w_len_nxt;
            r_ones <= w_ones_nxt;
            if (w_len_full) begin
              r_overrun <= 1'b1;
            end
            if (bus.bit_last) begin
              r_res_vals  <= w_conv;
              r_res_len   <= w_len_nxt;
              r_res_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Bits arriving while a result is held are never counted.
          if (bus.bit_valid) begin
            r_overrun <= 1'b1;
          end
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_ACC;
            r_len       <= {CNT_W{1'b0}};
            for (int k = 0; k < NUM_INPUTS; k++) begin
              r_ones[k] <= {CNT_W{1'b0}};
            end
          end
        end
        default: begin
          r_state     <= S_ACC;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_vals  = r_res_vals;
  assign bus.res_len   = r_res_len;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_sc_et_accum.sv
// Self-checking bench for sc_et_accum: directed scenarios plus randomized
// power-of-two runs checked against an arithmetic reference model.
module tb_sc_et_accum;

  localparam int W = 4;
  localparam int N = 2;

  logic clk;
  logic rst_n;
  logic clear;
  int   total;
  int   bad;

  sc_et_accum_if #(.WIDTH(W), .NUM_INPUTS(N)) bus ();

  sc_et_accum #(.WIDTH(W), .NUM_INPUTS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value = ones * 2^W / len, saturated to 2^W - 1.
  function automatic logic [W-1:0] ref_conv(input int ones, input int len);
    int v;
    v = (ones * (1 << W)) / len;
    if (v > (1 << W) - 1) v = (1 << W) - 1;
    return v[W-1:0];
  endfunction

  function automatic logic [255:0] first_ones(input int n);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic send_run(input int len, input logic [255:0] x0, input logic [255:0] x1);
    for (int i = 0; i < len; i++) begin
      bus.bit_valid = 1'b1;
      bus.Xs        = {x1[i], x0[i]};
      bus.bit_last  = (i == len - 1);
      @(posedge clk); #1;
    end
    bus.bit_valid = 1'b0;
    bus.bit_last  = 1'b0;
    bus.Xs        = 2'b00;
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.res_valid !== 1'b0 || bus.res_vals !== 8'h00 || bus.res_len !== 9'd0 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset: got valid=%b vals=%h len=%0d ovr=%b want 0/00/0/0",
               bus.res_valid, bus.res_vals, bus.res_len, bus.overrun);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_len8();
    send_run(8, first_ones(6), first_ones(4));
    total++;
    if (bus.res_valid !== 1'b1) begin
      bad++; $display("FAIL basic_valid: got %b want 1", bus.res_valid);
    end
    total++;
    if (bus.res_vals !== 8'h8C || bus.res_len !== 9'd8) begin
      bad++; $display("FAIL basic_result: got vals=%h len=%0d want 8c/8", bus.res_vals, bus.res_len);
    end
    consume();
  endtask

  task automatic test_long_256();
    send_run(256, first_ones(208), first_ones(144));
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_vals !== 8'h9D || bus.res_len !== 9'd256) begin
      bad++; $display("FAIL long_256: got valid=%b vals=%h len=%0d want 1/9d/256",
                      bus.res_valid, bus.res_vals, bus.res_len);
    end
    consume();
  endtask

  task automatic test_saturation();
    send_run(16, first_ones(16), first_ones(0));
    total++;
    if (bus.res_vals !== 8'h0F || bus.res_len !== 9'd16) begin
      bad++; $display("FAIL saturation: got vals=%h len=%0d want 0f/16", bus.res_vals, bus.res_len);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    send_run(8, first_ones(6), first_ones(4));
    for (int c = 0; c < 5; c++) begin
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_vals !== 8'h8C || bus.res_len !== 9'd8) begin
        bad++; $display("FAIL hold_stable[%0d]: got valid=%b vals=%h len=%0d want 1/8c/8",
                        c, bus.res_valid, bus.res_vals, bus.res_len);
      end
      bus.bit_valid = (c == 1);
      bus.Xs        = 2'b11;
      @(posedge clk); #1;
    end
    bus.bit_valid = 1'b0;
    bus.Xs        = 2'b00;
    total++;
    if (bus.overrun !== 1'b1 || bus.res_len !== 9'd8 || bus.res_vals !== 8'h8C) begin
      bad++; $display("FAIL hold_overrun: got ovr=%b len=%0d vals=%h want 1/8/8c",
                      bus.overrun, bus.res_len, bus.res_vals);
    end
    consume();
    total++;
    if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL release_valid: got %b want 0", bus.res_valid);
    end
    send_run(8, first_ones(2), first_ones(8));
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_vals !== 8'hF4 || bus.res_len !== 9'd8) begin
      bad++; $display("FAIL second_run: got valid=%b vals=%h len=%0d want 1/f4/8",
                      bus.res_valid, bus.res_vals, bus.res_len);
    end
    consume();
  endtask

  task automatic test_clear_mid_run();
    for (int i = 0; i < 3; i++) begin
      bus.bit_valid = 1'b1;
      bus.Xs        = 2'b11;
      @(posedge clk); #1;
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear         = 1'b0;
    bus.bit_valid = 1'b0;
    bus.Xs        = 2'b00;
    total++;
    if (bus.overrun !== 1'b0 || bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL clear_flags: got ovr=%b valid=%b want 0/0", bus.overrun, bus.res_valid);
    end
    send_run(8, first_ones(2), first_ones(5));
    total++;
    if (bus.res_vals !== 8'hA4 || bus.res_len !== 9'd8) begin
      bad++; $display("FAIL clear_run: got vals=%h len=%0d want a4/8", bus.res_vals, bus.res_len);
    end
    consume();
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int len;
      int ones0;
      int ones1;
      int waitc;
      logic [255:0] x0;
      logic [255:0] x1;
      logic [7:0]   exp_vals;
      logic [8:0]   exp_len;
      len   = 1 << $urandom_range(0, 8);
      ones0 = 0;
      ones1 = 0;
      x0    = '0;
      x1    = '0;
      for (int i = 0; i < len; i++) begin
        x0[i] = $urandom_range(0, 1);
        x1[i] = ($urandom_range(0, 3) != 0);
        ones0 += int'(x0[i]);
        ones1 += int'(x1[i]);
      end
      exp_vals = {ref_conv(ones1, len), ref_conv(ones0, len)};
      exp_len  = len[8:0];
      send_run(len, x0, x1);
      waitc = $urandom_range(0, 3);
      for (int c = 0; c <= waitc; c++) begin
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_vals !== exp_vals || bus.res_len !== exp_len) begin
          bad++; $display("FAIL random[%0d]: got valid=%b vals=%h len=%0d want 1/%h/%0d",
                          r, bus.res_valid, bus.res_vals, bus.res_len, exp_vals, exp_len);
        end
        if (c < waitc) begin
          @(posedge clk); #1;
        end
      end
      consume();
      total++;
      if (bus.res_valid !== 1'b0) begin
        bad++; $display("FAIL random_release[%0d]: got %b want 0", r, bus.res_valid);
      end
    end
  endtask

  task automatic test_async_reset_hold();
    send_run(8, first_ones(3), first_ones(7));
    bus.bit_valid = 1'b1;
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
    total++;
    if (bus.res_valid !== 1'b1 || bus.overrun !== 1'b1 || bus.res_vals !== 8'hE6) begin
      bad++; $display("FAIL pre_async: got valid=%b ovr=%b vals=%h want 1/1/e6",
                      bus.res_valid, bus.overrun, bus.res_vals);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.res_valid !== 1'b0 || bus.res_vals !== 8'h00 || bus.res_len !== 9'd0 || bus.overrun !== 1'b0) begin
      bad++; $display("FAIL async_reset: got valid=%b vals=%h len=%0d ovr=%b want 0/00/0/0",
                      bus.res_valid, bus.res_vals, bus.res_len, bus.overrun);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    clear         = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_last  = 1'b0;
    bus.Xs        = 2'b00;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic_len8();
    test_long_256();
    test_saturation();
    test_back_to_back();
    test_clear_mid_run();
    test_random();
    test_async_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
